lcl_mem_responder: RTL

LCL_MEM_RESPONDER -- requirements
Module: lcl_mem_responder

---
 rtl/lcl_mem_responder_if.sv | 42 ++++
 rtl/lcl_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lcl_mem_responder_if.sv
// Local memory bus: write-burst channel, read-burst channel and the sticky error flag.
// The responder takes the slave modport; an initiator (or bench) takes master.
interface lcl_mem_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  // Handshake: a write beat moves on a rising edge where lcl_den & lcl_irdy are both 1,
  // a read beat is accepted where lcl_rden & lcl_ordy are both 1 and its data appears
  // with lcl_dv one cycle later; start requests are only taken while the channel is idle.
  logic                  lcl_istart;
  logic [ADDR_WIDTH-1:0] lcl_iaddr;
  logic [7:0]            lcl_inum;
  logic                  lcl_ibusy;
  logic                  lcl_irdy;
  logic                  lcl_den;
  logic [DATA_WIDTH-1:0] lcl_din;
  logic                  lcl_idone;

  logic                  lcl_ostart;
  logic [ADDR_WIDTH-1:0] lcl_oaddr;
  logic [7:0]            lcl_onum;
  logic                  lcl_obusy;
  logic                  lcl_ordy;
  logic                  lcl_rden;
  logic                  lcl_dv;
  logic [DATA_WIDTH-1:0] lcl_dout;
  logic                  lcl_odone;

  logic                  err_ovf;

  modport master (
    output lcl_istart, lcl_iaddr, lcl_inum, lcl_den, lcl_din, lcl_idone,
    output lcl_ostart, lcl_oaddr, lcl_onum, lcl_rden,
    input  lcl_ibusy, lcl_irdy, lcl_obusy, lcl_ordy, lcl_dv, lcl_dout, lcl_odone, err_ovf
  );

  modport slave (
    input  lcl_istart, lcl_iaddr, lcl_inum, lcl_den, lcl_din, lcl_idone,
    input  lcl_ostart, lcl_oaddr, lcl_onum, lcl_rden,
    output lcl_ibusy, lcl_irdy, lcl_obusy, lcl_ordy, lcl_dv, lcl_dout, lcl_odone, err_ovf
  );
endinterface

// File: rtl/lcl_mem_responder.sv
// Burst memory responder: independent write and read FSMs around a 2^MEM_AW-beat dual-port RAM.
// Optional LCL_RSP_BACKPRESSURE_EN drops both ready signals one cycle in every four.
module lcl_mem_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int MEM_AW     = 6
) (
  input  logic               clk,
  input  logic               rst,
  lcl_mem_responder_if.slave bus,
  output logic [1:0]         o_dbg_wstate,
  output logic [1:0]         o_dbg_rstate
);
  localparam int BPB_LOG = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH   = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1, R_LAST = 2'd2} r_state_t;

  w_state_t              r_wstate;
  r_state_t              r_rstate;
  logic [MEM_AW-1:0]     r_wptr;
  logic [MEM_AW-1:0]     r_rptr;
  logic [7:0]            r_wrem;
  logic [7:0]            r_rrem;
  logic                  r_ibusy;
  logic                  r_irdy;
  logic                  r_obusy;
  logic                  r_ordy;
  logic                  r_dv;
  logic                  r_odone;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_bp_stall;
  logic w_irdy;
  logic w_ordy;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_err_set;
  logic w_addr_unused;

`ifdef LCL_RSP_BACKPRESSURE_EN
  logic [1:0] r_bp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bp_cnt <= 2'd0;
    else     r_bp_cnt <= r_bp_cnt + 2'd1;
  end

  assign w_bp_stall = (r_bp_cnt == 2'd3);
`else
  assign w_bp_stall = 1'b0;
`endif

  assign w_irdy    = r_irdy & ~w_bp_stall;
  assign w_ordy    = r_ordy & ~w_bp_stall;
  assign w_wr_acc  = bus.lcl_den & w_irdy;
  assign w_rd_acc  = bus.lcl_rden & w_ordy;
  assign w_err_set = (bus.lcl_den & ~w_irdy) | (bus.lcl_rden & ~w_ordy) |
                     (bus.lcl_idone & (r_wstate == W_DATA));

  // Only the beat-index slice of each address is used; the rest is folded here.
  assign w_addr_unused = ^{bus.lcl_iaddr, bus.lcl_oaddr};

  // Write channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wptr   <= '0;
      r_wrem   <= 8'd0;
      r_ibusy  <= 1'b0;
      r_irdy   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (bus.lcl_istart) begin
          r_wptr  <= bus.lcl_iaddr[BPB_LOG +: MEM_AW];
          r_wrem  <= bus.lcl_inum;
          r_ibusy <= 1'b1;
          if (bus.lcl_inum == 8'd0) begin
            r_wstate <= W_WAIT;
          end else begin
            r_wstate <= W_DATA;
            r_irdy   <= 1'b1;
          end
        end
        W_DATA: if (w_wr_acc) begin
          r_wptr <= r_wptr + IDX_ONE;
          r_wrem <= r_wrem - 8'd1;
          if (r_wrem == 8'd1) begin
            r_wstate <= W_WAIT;
            r_irdy   <= 1'b0;
          end
        end
        W_WAIT: if (bus.lcl_idone) begin
          r_wstate <= W_IDLE;
          r_ibusy  <= 1'b0;
        end
        default: begin
          r_wstate <= W_IDLE;
          r_ibusy  <= 1'b0;
          r_irdy   <= 1'b0;
        end
      endcase
    end
  end

  // RAM keeps its contents across reset; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= bus.lcl_din;
  end

  // Read channel; odone is raised on the last accepted beat so it lands with the last dv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rptr   <= '0;
      r_rrem   <= 8'd0;
      r_obusy  <= 1'b0;
      r_ordy   <= 1'b0;
      r_dv     <= 1'b0;
      r_odone  <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_dv    <= 1'b0;
      r_odone <= 1'b0;
      case (r_rstate)
        R_IDLE: if (bus.lcl_ostart) begin
          r_rptr <= bus.lcl_oaddr[BPB_LOG +: MEM_AW];
          r_rrem <= bus.lcl_onum;
          if (bus.lcl_onum == 8'd0) begin
            r_odone <= 1'b1;
          end else begin
            r_rstate <= R_DATA;
            r_obusy  <= 1'b1;
            r_ordy   <= 1'b1;
          end
        end
        R_DATA: if (w_rd_acc) begin
          r_dout <= r_mem[r_rptr];
          r_dv   <= 1'b1;
          r_rptr <= r_rptr + IDX_ONE;
          r_rrem <= r_rrem - 8'd1;
          if (r_rrem == 8'd1) begin
            r_rstate <= R_LAST;
            r_ordy   <= 1'b0;
            r_odone  <= 1'b1;
          end
        end
        R_LAST: begin
          r_rstate <= R_IDLE;
          r_obusy  <= 1'b0;
        end
        default: begin
          r_rstate <= R_IDLE;
          r_obusy  <= 1'b0;
          r_ordy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign bus.lcl_ibusy = r_ibusy;
  assign bus.lcl_irdy  = w_irdy;
  assign bus.lcl_obusy = r_obusy;
  assign bus.lcl_ordy  = w_ordy;
  assign bus.lcl_dv    = r_dv;
  assign bus.lcl_dout  = r_dout;
  assign bus.lcl_odone = r_odone;
  assign bus.err_ovf   = r_err;
  assign o_dbg_wstate  = r_wstate;
  assign o_dbg_rstate  = r_rstate;
endmodule
